// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the RV32I-subset core: decodes the instruction
// register and drives ALU op, operand selects and datapath/memory strobes.
module multicycle_control #(
    parameter bit TRAP_STICKY = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        adr_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [3:0]  alu_control,
    output logic [3:0]  state,
    output logic        illegal
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_TRAP     = 4'd15
    } state_t;

    state_t state_q;
    state_t state_d;
    state_t decode_next;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;
    logic [3:0] mapped_op;
    logic [3:0] branch_op;
    logic       branch_take;
    logic       r_bad;
    logic       i_bad;
    logic       b_bad;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign funct7        = instr[31:25];
    assign unused_fields = ^{instr[24:15], instr[11:7]};
    assign state         = state_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Encoding checks that turn an otherwise valid opcode into a trap
    always_comb begin
        r_bad = ((funct7 != F7_BASE) && (funct7 != F7_ALT)) ||
                ((funct7 == F7_ALT) && (funct3 != 3'b000) && (funct3 != 3'b101));
        i_bad = ((funct3 == 3'b001) && (funct7 != F7_BASE)) ||
                ((funct3 == 3'b101) && (funct7 != F7_BASE) && (funct7 != F7_ALT));
        b_bad = (funct3 == 3'b010) || (funct3 == 3'b011);
    end

    always_comb begin
        decode_next = S_TRAP;
        case (opcode)
            OP_R:               decode_next = r_bad ? S_TRAP : S_EXEC_R;
            OP_I:               decode_next = i_bad ? S_TRAP : S_EXEC_I;
            OP_LOAD, OP_STORE:  decode_next = S_MEM_ADDR;
            OP_BRANCH:          decode_next = b_bad ? S_TRAP : S_BRANCH;
            OP_JAL:             decode_next = S_JAL;
            OP_LUI:             decode_next = S_LUI;
            default:            decode_next = S_TRAP;
        endcase
    end

    // funct3 -> ALU op; instr[30] selects SUB only for R-type, SRA for both
    always_comb begin
        mapped_op = ALU_ADD;
        case (funct3)
            3'b000:  mapped_op = ((opcode == OP_R) && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  mapped_op = ALU_SLL;
            3'b010:  mapped_op = ALU_SLT;
            3'b011:  mapped_op = ALU_SLTU;
            3'b100:  mapped_op = ALU_XOR;
            3'b101:  mapped_op = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  mapped_op = ALU_OR;
            default: mapped_op = ALU_AND;
        endcase
    end

    // Branch compare op and taken condition from the ALU zero flag
    always_comb begin
        branch_op   = ALU_SUB;
        branch_take = 1'b0;
        case (funct3)
            3'b000:  begin branch_op = ALU_SUB;  branch_take = zero;  end
            3'b001:  begin branch_op = ALU_SUB;  branch_take = !zero; end
            3'b100:  begin branch_op = ALU_SLT;  branch_take = !zero; end
            3'b101:  begin branch_op = ALU_SLT;  branch_take = zero;  end
            3'b110:  begin branch_op = ALU_SLTU; branch_take = !zero; end
            3'b111:  begin branch_op = ALU_SLTU; branch_take = zero;  end
            default: begin branch_op = ALU_SUB;  branch_take = 1'b0;  end
        endcase
    end

    // Next state and combinational outputs
    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        adr_src     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_control = ALU_ADD;
        illegal     = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                state_d   = decode_next;
            end
            S_EXEC_R: begin
                alu_src_a   = 2'b10;
                alu_control = mapped_op;
                state_d     = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = mapped_op;
                state_d     = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = opcode[5] ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = branch_op;
                pc_write    = branch_take;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                pc_write  = 1'b1;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = S_ALU_WB;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                state_d   = S_ALU_WB;
            end
            S_TRAP: begin
                illegal = 1'b1;
                state_d = TRAP_STICKY ? S_TRAP : S_FETCH;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        // Quiesce every output while reset is asserted
        if (!rst_n) begin
            pc_write    = 1'b0;
            ir_write    = 1'b0;
            adr_src     = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            reg_write   = 1'b0;
            alu_src_a   = 2'b00;
            alu_src_b   = 2'b00;
            result_src  = 2'b00;
            alu_control = ALU_ADD;
            illegal     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected output
// vectors are queued when inputs are driven and compared when sampled.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [3:0]  alu_control, state;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    logic [20:0] exp_q[$];
    string       tag_q[$];

    // strobe bit order: {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, illegal}
    localparam logic [6:0] S_NONE  = 7'b0000000;
    localparam logic [6:0] S_FETCH = 7'b1101000;
    localparam logic [6:0] S_FWAIT = 7'b0001000;
    localparam logic [6:0] S_RW    = 7'b0000010;
    localparam logic [6:0] S_MRD   = 7'b0011000;
    localparam logic [6:0] S_MWR   = 7'b0010100;
    localparam logic [6:0] S_PCW   = 7'b1000000;
    localparam logic [6:0] S_ILL   = 7'b0000001;

    multicycle_control dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .adr_src     (adr_src),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .alu_control (alu_control),
        .state       (state),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] vec(input logic [3:0] st, input logic [3:0] alu,
                                        input logic [1:0] a, input logic [1:0] b,
                                        input logic [1:0] rs, input logic [6:0] s);
        return {st, alu, a, b, rs, s};
    endfunction

    task automatic check(input string tag, input logic [20:0] got, input logic [20:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got st=%0d alu=%b a=%b b=%b rs=%b strobes=%b, want st=%0d alu=%b a=%b b=%b rs=%b strobes=%b",
                     tag, got[20:17], got[16:13], got[12:11], got[10:9], got[8:7], got[6:0],
                     want[20:17], want[16:13], want[12:11], want[10:9], want[8:7], want[6:0]);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, queue the expectation,
    // sample the combinational outputs before the next rising edge.
    task automatic step(input string tag, input logic rn, input logic [31:0] ins,
                        input logic z, input logic mr, input logic [20:0] want);
        logic [20:0] got;
        @(negedge clk);
        rst_n = rn; instr = ins; zero = z; mem_ready = mr;
        exp_q.push_back(want);
        tag_q.push_back(tag);
        #2;
        got = {state, alu_control, alu_src_a, alu_src_b, result_src,
               pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, illegal};
        check(tag_q.pop_front(), got, exp_q.pop_front());
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        rst_n = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    endtask

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SRA  = 32'h4020D1B3;
    localparam logic [31:0] I_SRAI = 32'h4010D193;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_BLT  = 32'h0020C463;
    localparam logic [31:0] I_JAL  = 32'h0000006F;
    localparam logic [31:0] I_LUI  = 32'h000001B7;
    localparam logic [31:0] I_BAD  = 32'h0000007F;
    localparam logic [31:0] I_BF7  = 32'h042081B3;
    localparam logic [31:0] I_BB3  = 32'h0020A463;

    logic [20:0] v_fetch, v_decode, v_alu_wb;

    initial begin
        v_fetch  = vec(4'd0, 4'b0000, 2'b00, 2'b10, 2'b10, S_FETCH);
        v_decode = vec(4'd1, 4'b0000, 2'b01, 2'b01, 2'b00, S_NONE);
        v_alu_wb = vec(4'd8, 4'b0000, 2'b00, 2'b00, 2'b00, S_RW);

        rst_n = 1'b0; instr = 32'h0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        step("reset_hold", 1'b0, I_ADD, 1'b0, 1'b1, vec(4'd0, 4'b0000, 2'b00, 2'b00, 2'b00, S_NONE));

        // add x3,x1,x2
        step("add_fetch",  1'b1, I_ADD, 1'b0, 1'b1, v_fetch);
        step("add_decode", 1'b1, I_ADD, 1'b0, 1'b1, v_decode);
        step("add_exec",   1'b1, I_ADD, 1'b0, 1'b1, vec(4'd2, 4'b0000, 2'b10, 2'b00, 2'b00, S_NONE));
        step("add_wb",     1'b1, I_ADD, 1'b0, 1'b1, v_alu_wb);

        // sra / srai
        step("sra_fetch",  1'b1, I_SRA, 1'b0, 1'b1, v_fetch);
        step("sra_decode", 1'b1, I_SRA, 1'b0, 1'b1, v_decode);
        step("sra_exec",   1'b1, I_SRA, 1'b0, 1'b1, vec(4'd2, 4'b0111, 2'b10, 2'b00, 2'b00, S_NONE));
        step("sra_wb",     1'b1, I_SRA, 1'b0, 1'b1, v_alu_wb);
        step("srai_fetch", 1'b1, I_SRAI, 1'b0, 1'b1, v_fetch);
        step("srai_decode",1'b1, I_SRAI, 1'b0, 1'b1, v_decode);
        step("srai_exec",  1'b1, I_SRAI, 1'b0, 1'b1, vec(4'd3, 4'b0111, 2'b10, 2'b01, 2'b00, S_NONE));
        step("srai_wb",    1'b1, I_SRAI, 1'b0, 1'b1, v_alu_wb);

        // lw with a fetch wait and three read wait cycles
        step("lw_fwait",   1'b1, I_LW, 1'b0, 1'b0, vec(4'd0, 4'b0000, 2'b00, 2'b00, 2'b00, S_FWAIT));
        step("lw_fetch",   1'b1, I_LW, 1'b0, 1'b1, v_fetch);
        step("lw_decode",  1'b1, I_LW, 1'b0, 1'b1, v_decode);
        step("lw_addr",    1'b1, I_LW, 1'b0, 1'b1, vec(4'd4, 4'b0000, 2'b10, 2'b01, 2'b00, S_NONE));
        for (int i = 0; i < 3; i++)
            step("lw_rd_wait", 1'b1, I_LW, 1'b0, 1'b0, vec(4'd5, 4'b0000, 2'b00, 2'b00, 2'b00, S_MRD));
        step("lw_rd_done", 1'b1, I_LW, 1'b0, 1'b1, vec(4'd5, 4'b0000, 2'b00, 2'b00, 2'b00, S_MRD));
        step("lw_wb",      1'b1, I_LW, 1'b0, 1'b1, vec(4'd6, 4'b0000, 2'b00, 2'b00, 2'b01, S_RW));

        // branches
        step("beq_fetch",  1'b1, I_BEQ, 1'b0, 1'b1, v_fetch);
        step("beq_decode", 1'b1, I_BEQ, 1'b0, 1'b1, v_decode);
        step("beq_taken",  1'b1, I_BEQ, 1'b1, 1'b1, vec(4'd9, 4'b0001, 2'b10, 2'b00, 2'b00, S_PCW));
        step("beq2_fetch", 1'b1, I_BEQ, 1'b0, 1'b1, v_fetch);
        step("beq2_decode",1'b1, I_BEQ, 1'b0, 1'b1, v_decode);
        step("beq_not",    1'b1, I_BEQ, 1'b0, 1'b1, vec(4'd9, 4'b0001, 2'b10, 2'b00, 2'b00, S_NONE));
        step("blt_fetch",  1'b1, I_BLT, 1'b0, 1'b1, v_fetch);
        step("blt_decode", 1'b1, I_BLT, 1'b0, 1'b1, v_decode);
        step("blt_zero",   1'b1, I_BLT, 1'b1, 1'b1, vec(4'd9, 4'b0011, 2'b10, 2'b00, 2'b00, S_NONE));
        step("blt2_fetch", 1'b1, I_BLT, 1'b0, 1'b1, v_fetch);
        step("blt2_decode",1'b1, I_BLT, 1'b0, 1'b1, v_decode);
        step("blt_taken",  1'b1, I_BLT, 1'b0, 1'b1, vec(4'd9, 4'b0011, 2'b10, 2'b00, 2'b00, S_PCW));

        // jal and lui
        step("jal_fetch",  1'b1, I_JAL, 1'b0, 1'b1, v_fetch);
        step("jal_decode", 1'b1, I_JAL, 1'b0, 1'b1, v_decode);
        step("jal_exec",   1'b1, I_JAL, 1'b0, 1'b1, vec(4'd10, 4'b0000, 2'b01, 2'b10, 2'b00, S_PCW));
        step("jal_wb",     1'b1, I_JAL, 1'b0, 1'b1, v_alu_wb);
        step("lui_fetch",  1'b1, I_LUI, 1'b0, 1'b1, v_fetch);
        step("lui_decode", 1'b1, I_LUI, 1'b0, 1'b1, v_decode);
        step("lui_exec",   1'b1, I_LUI, 1'b0, 1'b1, vec(4'd11, 4'b0000, 2'b11, 2'b01, 2'b00, S_NONE));
        step("lui_wb",     1'b1, I_LUI, 1'b0, 1'b1, v_alu_wb);

        // store completing normally, then a store cut off by reset
        step("sw_fetch",   1'b1, I_SW, 1'b0, 1'b1, v_fetch);
        step("sw_decode",  1'b1, I_SW, 1'b0, 1'b1, v_decode);
        step("sw_addr",    1'b1, I_SW, 1'b0, 1'b1, vec(4'd4, 4'b0000, 2'b10, 2'b01, 2'b00, S_NONE));
        step("sw_write",   1'b1, I_SW, 1'b0, 1'b1, vec(4'd7, 4'b0000, 2'b00, 2'b00, 2'b00, S_MWR));
        step("sw2_fetch",  1'b1, I_SW, 1'b0, 1'b1, v_fetch);
        step("sw2_decode", 1'b1, I_SW, 1'b0, 1'b1, v_decode);
        step("sw2_addr",   1'b1, I_SW, 1'b0, 1'b1, vec(4'd4, 4'b0000, 2'b10, 2'b01, 2'b00, S_NONE));
        step("sw2_wait",   1'b1, I_SW, 1'b0, 1'b0, vec(4'd7, 4'b0000, 2'b00, 2'b00, 2'b00, S_MWR));
        step("sw2_rst",    1'b0, I_SW, 1'b0, 1'b1, vec(4'd7, 4'b0000, 2'b00, 2'b00, 2'b00, S_NONE));
        step("sw2_after",  1'b1, I_SW, 1'b0, 1'b0, vec(4'd0, 4'b0000, 2'b00, 2'b00, 2'b00, S_FWAIT));

        // illegal opcode: sticky trap until reset
        step("bad_fetch",  1'b1, I_BAD, 1'b0, 1'b1, v_fetch);
        step("bad_decode", 1'b1, I_BAD, 1'b0, 1'b1, v_decode);
        for (int i = 0; i < 5; i++)
            step("trap_hold", 1'b1, I_BAD, 1'b0, 1'b1, vec(4'd15, 4'b0000, 2'b00, 2'b00, 2'b00, S_ILL));
        reset_cycle();
        step("trap_reset", 1'b1, I_BF7, 1'b0, 1'b1, v_fetch);

        // R-type with bad funct7, then branch with reserved funct3
        step("bf7_decode", 1'b1, I_BF7, 1'b0, 1'b1, v_decode);
        step("bf7_trap",   1'b1, I_BF7, 1'b0, 1'b1, vec(4'd15, 4'b0000, 2'b00, 2'b00, 2'b00, S_ILL));
        reset_cycle();
        step("bb3_fetch",  1'b1, I_BB3, 1'b0, 1'b1, v_fetch);
        step("bb3_decode", 1'b1, I_BB3, 1'b0, 1'b1, v_decode);
        step("bb3_trap",   1'b1, I_BB3, 1'b0, 1'b1, vec(4'd15, 4'b0000, 2'b00, 2'b00, 2'b00, S_ILL));
        reset_cycle();
        step("final_fetch",1'b1, I_ADD, 1'b0, 1'b1, v_fetch);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM for the RV32I-subset core; the producer end of the ALU interface.
- Decodes the instruction register and drives `alu_control` (ALU encoding below), operand selects and datapath/memory strobes.
- Consumes the ALU `zero` flag for branch resolution and a memory `mem_ready` handshake.
- Sits between the instruction register and the datapath muxes, register file and memory port.

Parameters:
- TRAP_STICKY, 1, 1: TRAP holds until reset. 0: TRAP returns to FETCH after one cycle.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- instr  input  32  instruction register contents, stable from DECODE onward
- zero  input  1  ALU zero flag, combinational from the current-cycle operands
- mem_ready  input  1  memory completes the current read or write this cycle
- pc_write  output  1  load PC from the result bus
- ir_write  output  1  load instruction register from memory data
- adr_src  output  1  memory address select: 0 = PC, 1 = ALU-out register
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- reg_write  output  1  register-file write of rd from the result bus
- alu_src_a  output  2  00 = PC, 01 = old_PC, 10 = rs1 register, 11 = zero
- alu_src_b  output  2  00 = rs2 register, 01 = immediate, 10 = constant 4
- result_src  output  2  00 = ALU-out register, 01 = memory data register, 10 = live ALU result
- alu_control  output  4  ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001
- state  output  4  current state, for debug
- illegal  output  1  high in TRAP

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset:
  - A rising edge with rst_n=0 forces state to FETCH (0) from any state, including TRAP and mid-memory-wait.
  - While rst_n=0, every strobe output is 0, alu_control=0000 and all selects are 00.
- Output style:
  - Outputs are combinational from state, instr, zero and mem_ready.
  - Defaults in every state: all strobes 0, selects 00, alu_control ADD.
- The ALU-out register is external and latches the ALU result every cycle.
- States and encodings:
  - FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, ALU_WB=8, BRANCH=9, JAL=10, LUI=11, TRAP=15.
- FETCH:
  - mem_read=1, adr_src=0.
  - mem_ready=0: hold state, all other strobes 0.
  - mem_ready=1: ir_write=1, pc_write=1, a=00, b=10, ADD, result_src=10; go to DECODE.
- DECODE:
  - a=01, b=01, ADD (branch/jump target into ALU-out).
  - Next state by opcode:
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0000011 or 0100011 -> MEM_ADDR
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 0110111 -> LUI
    - anything else -> TRAP
  - Also TRAP when any of these holds:
    - R-type funct7 is not 0x00/0x20.
    - R-type funct7=0x20 with funct3 not 000/101.
    - SLLI with funct7 not 0.
    - SRLI/SRAI with funct7 not 0x00/0x20.
    - Branch funct3 is 010 or 011.
- ALU op map, funct3 -> alu_control:
  - 000 -> ADD (SUB if R-type and funct7[5]=1)
  - 001 -> SLL
  - 010 -> SLT
  - 011 -> SLTU
  - 100 -> XOR
  - 101 -> SRL (SRA if funct7[5]=1)
  - 110 -> OR
  - 111 -> AND
  - ADDI ignores instr[30].
- EXEC_R: a=10, b=00, mapped op; go to ALU_WB.
- EXEC_I: a=10, b=01, mapped op; go to ALU_WB.
- ALU_WB: result_src=00, reg_write=1; go to FETCH.
- MEM_ADDR: a=10, b=01, ADD; go to MEM_RD for a load, MEM_WR for a store.
- MEM_RD:
  - adr_src=1, mem_read=1 held until mem_ready.
  - On mem_ready, go to MEM_WB.
- MEM_WB: result_src=01, reg_write=1; go to FETCH.
- MEM_WR:
  - adr_src=1, mem_write=1 held until mem_ready.
  - On mem_ready, go to FETCH.
  - Exactly one write is accepted per store.
- BRANCH:
  - a=10, b=00, result_src=00.
  - BEQ/BNE use SUB; BLT/BGE use SLT; BLTU/BGEU use SLTU.
  - pc_write is asserted in the same cycle as follows:
    - BEQ: zero
    - BNE: !zero
    - BLT: !zero
    - BGE: zero
    - BLTU: !zero
    - BGEU: zero
  - Then go to FETCH.
- JAL:
  - pc_write=1, result_src=00 (target).
  - a=01, b=10, ADD, so old_PC+4 lands in ALU-out.
  - Go to ALU_WB, which writes the link register.
- LUI: a=11, b=01, ADD; go to ALU_WB.
- TRAP:
  - illegal=1, all strobes 0.
  - TRAP_STICKY=1: stay in TRAP. TRAP_STICKY=0: go to FETCH next cycle.

Test Plan:
- Reset, then instr=0x002081B3 (add x3,x1,x2), mem_ready=1 -> state 0,1,2,8,0 on consecutive cycles; alu_control=0000 in EXEC_R; reg_write=1 only in ALU_WB.
- instr=0x4020D1B3 (sra) -> EXEC_R alu_control=0111, b=00. instr=0x4010D193 (srai) -> EXEC_I alu_control=0111, b=01.
- instr=0x0000A183 (lw), mem_ready=0 for 3 cycles in MEM_RD -> state holds at 5 with mem_read=1 and adr_src=1; then MEM_WB with result_src=01, reg_write=1.
- instr=0x00208463 (beq), zero=1 -> BRANCH alu_control=0001, pc_write=1. instr=0x0020C463 (blt), zero=1 -> alu_control=0011, pc_write=0.
- instr=0x0000007F -> DECODE goes to TRAP; illegal=1 and state=15 held for 5 cycles; one rst_n=0 edge -> FETCH, illegal=0.
- rst_n=0 during MEM_WR with mem_write=1 -> mem_write drops in the same cycle; state=0 after the edge; no write is issued.
